// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access sequencer: decodes MIPS loads/stores, drives a req/ack memory port
// and registers the extended load result. Optional misaligned-access trap: MISALIGN_TRAP_EN.
module dm_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidM,
  input  logic [31:0] InstrM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WDataM,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        BusErr,
  output logic        AdErr
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       op_q;
  logic [1:0]       a_q;
  logic             bus_err_q;
  logic             ad_err_q;

  logic [5:0]  op;
  logic        is_load, is_store, is_word, is_half;
  logic [1:0]  a_eff;
  logic        misalign;
  logic        start;
  logic        timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_ext;

  assign op = InstrM[31:26];

  logic unused_instr;
  assign unused_instr = ^InstrM[25:0];

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_word  = 1'b0;
    is_half  = 1'b0;
    case (op)
      OP_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      OP_LH, OP_LHU:  begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LB, OP_LBU:  is_load = 1'b1;
      OP_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      OP_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      OP_SB:          is_store = 1'b1;
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign a_eff    = AddrM[1:0];
  assign misalign = (is_word && AddrM[1:0] != 2'b00) || (is_half && AddrM[0]);
`else
  // Low address bits a word/halfword cannot use are ignored rather than trapped.
  assign a_eff    = is_word ? 2'b00 : (is_half ? {AddrM[1], 1'b0} : AddrM[1:0]);
  assign misalign = 1'b0;
`endif

  // Gated by rst_n so Stall drops with reset even while an access is presented.
  assign start       = rst_n & ValidM & (is_load | is_store) & (state == IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  assign Stall     = start | (state == REQ);
  assign mem_req   = (state == REQ);
  assign BusErr    = (state == DONE) & bus_err_q;
  assign LoadValid = (state == DONE) & ~mem_we & ~ad_err_q;

`ifdef MISALIGN_TRAP_EN
  assign AdErr = (state == DONE) & ad_err_q;
`else
  assign AdErr = 1'b0;
`endif

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = WDataM;
    if (is_store && is_half) begin
      be_nxt    = a_eff[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{WDataM[15:0]}};
    end else if (is_store && !is_word) begin
      be_nxt    = 4'b0001 << a_eff;
      wdata_nxt = {4{WDataM[7:0]}};
    end
  end

  always_comb begin
    ld_half = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (a_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    case (op_q)
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'h0000, ld_half};
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'h000000, ld_byte};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = misalign ? DONE : REQ;
      REQ:     if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register,
  // so mem_req (decoded from state) falls the instant rst_n goes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      bus_err_q <= 1'b0;
      ad_err_q  <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      LoadData  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q      <= op;
          a_q       <= a_eff;
          mem_addr  <= {AddrM[31:2], 2'b00};
          mem_we    <= is_store;
          mem_be    <= be_nxt;
          mem_wdata <= wdata_nxt;
          bus_err_q <= 1'b0;
          ad_err_q  <= misalign;
          cnt       <= '0;
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) LoadData <= ld_ext;
            cnt <= '0;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
            LoadData  <= '0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
MEM-stage data-memory access sequencer for the 5-stage MIPS pipeline. Decodes load/store opcodes and drives a request/acknowledge data-memory port with word address, byte enables and lane-replicated store data. Stalls the pipeline until the memory acknowledges, then registers the sign- or zero-extended load result for the MEM/WB boundary.

Parameters:
TIMEOUT, 16, max cycles in REQ before abort; 0 = wait forever
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ValidM  in  1  MEM-stage instruction valid
InstrM  in  32  MEM-stage instruction; opcode in [31:26]
AddrM  in  32  effective byte address from ALU
WDataM  in  32  store source register value
Stall  out  1  hold IF/ID/EX/MEM stages
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_be  out  4  byte enables; bit i = byte lane [8i+7:8i]
mem_addr  out  32  word address {AddrM[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
LoadData  out  32  extracted load result, registered
LoadValid  out  1  one-cycle pulse, LoadData updated
BusErr  out  1  one-cycle pulse on timeout abort
AdErr  out  1  one-cycle pulse on misaligned access (macro only)

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset, asynchronous: state IDLE, counter 0. mem_req, mem_we, mem_be, mem_addr, mem_wdata, LoadData, LoadValid, BusErr and AdErr all 0. Stall 0.
- Reset asserted mid-REQ drops mem_req immediately, without waiting for the clock. A late mem_ack after reset is ignored.
- Opcodes:
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Any other opcode: no access.
- start = ValidM & access opcode & state IDLE.
- Stall = start | (state==REQ). Stall is combinational, so the stage freezes in the same cycle the access is seen.
- IDLE: on start, latch opcode, AddrM[1:0], mem_addr, mem_we, mem_be and mem_wdata. Next state REQ.
- REQ: mem_req=1. All latched outputs stay stable until the acknowledge arrives. The counter increments each cycle.
  - mem_ack: capture the load result (loads only). Next state DONE.
  - Counter reaches TIMEOUT (TIMEOUT!=0) with no ack: drop mem_req. Next state DONE, with BusErr pending and LoadData set to 0.
  - mem_ack in the same cycle as the timeout: ack wins, no BusErr.
- DONE: mem_req=0 and Stall=0, so the pipeline advances at the end of this cycle.
  - LoadValid=1 for loads; BusErr=1 if the access aborted.
  - DONE never starts a new access. Next state IDLE, so back-to-back accesses are spaced by at least one IDLE cycle.
  - Minimum latency with ack in the first REQ cycle: 3 cycles, 2 of them stalled.
- Store lanes, a = AddrM[1:0]:
  - sw: be=1111, wdata=WDataM.
  - sh: be=0011 if a[1]=0, 1100 if a[1]=1; wdata={WDataM[15:0],WDataM[15:0]}.
  - sb: be=0001<<a; wdata=4x WDataM[7:0].
- Loads: mem_be=1111. The result is extracted from mem_rdata on ack:
  - lw: whole word.
  - lh/lhu: half at a[1], sign- or zero-extended to 32.
  - lb/lbu: byte at a, sign- or zero-extended to 32.
- LoadData holds its value until the next load completes.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned access is trapped. Misaligned means lw/sw with a!=00, or lh/lhu/sh with a[0]=1.
  - start goes IDLE->DONE directly and no mem_req is issued.
  - Stall=1 for that one cycle only.
  - AdErr pulses in DONE; LoadValid=0, LoadData unchanged.
- Undefined: the AdErr port is tied 0. Ignored low address bits are forced to 0: word accesses use a=00, halfword accesses use a[0]=0.

Test Plan:
- lb at AddrM=0x0000_0013, ack first REQ cycle, mem_rdata=0x80FF_1234 -> mem_be=1111, mem_addr=0x10, LoadData=0xFFFF_FF80, LoadValid in cycle 3, Stall high cycles 1-2.
- sh at AddrM=0x22, WDataM=0xDEAD_BEEF, ack after 4 cycles -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF stable all 4 REQ cycles, LoadValid=0.
- lhu at 0x2, mem_rdata=0x9ABC_0000; then lw immediately next -> LoadData=0x0000_9ABC; exactly one IDLE cycle between the two mem_req periods.
- TIMEOUT=16, no ack -> mem_req drops after 16 cycles, BusErr pulse, LoadData=0, Stall released; the same scenario with ack on cycle 16 -> no BusErr.
- rst_n low during REQ -> mem_req and Stall 0 asynchronously; a subsequent mem_ack produces no LoadValid.
- With MISALIGN_TRAP_EN: lw at 0x6 -> no mem_req, AdErr pulse, one stall cycle. Without the macro: the same lw -> mem_addr=0x4, be=1111, normal completion.
